mdu_seq: RTL

Iterative multiply/divide sequencer for the execute stage: owns a shared shift-add multiplier and restoring divider and runs each operation over WIDTH cycles. It accepts one request at a time from execute and signals busy so hazard logic can stall the pipeline. A single-cycle done pulse returns the result for forwarding into the memory-stage register. Flush on redirect abandons an operation in flight.

---
 rtl/mdu_seq.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer: shift-add multiplier and restoring divider
// sharing one set of registers, one result bit per cycle over WIDTH cycles.
module mdu_seq #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_MUL  = 3'b000;
    localparam logic [2:0] OP_DIV  = 3'b001;
    localparam logic [2:0] OP_DIVU = 3'b010;
    localparam logic [2:0] OP_REM  = 3'b011;
    localparam logic [2:0] OP_REMU = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       op_q, op_d;
    // acc: product / partial remainder; x: multiplicand / divisor; y: multiplier / quotient
    logic [WIDTH-1:0] acc, acc_d;
    logic [WIDTH-1:0] x, x_d;
    logic [WIDTH-1:0] y, y_d;
    logic             neg_q, neg_q_d;
    logic             neg_r, neg_r_d;
    logic             busy_d, done_d;
    logic [WIDTH-1:0] result_d;

    logic             accept;
    logic             is_signed;
    logic             is_div;
    logic             is_rem;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   div_r;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [WIDTH-1:0] quo_nxt, rem_nxt;
    logic [WIDTH-1:0] final_res;

    assign ready = (state == S_IDLE) || (state == S_DONE);

    // Operand decode for a new request
    always_comb begin
        accept    = valid && ready && !flush;
        is_signed = (op == OP_DIV) || (op == OP_REM);
        is_div    = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
        is_rem    = (op == OP_REM) || (op == OP_REMU);
        abs_a     = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        abs_b     = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    end

    // One iteration of each datapath plus final sign fix-up
    always_comb begin
        mul_acc = y[0] ? (acc + x) : acc;
        div_r   = {acc, y[WIDTH-1]};
        div_ge  = (div_r >= {1'b0, x});
        div_sub = div_r[WIDTH-1:0] - x;
        quo_nxt = {y[WIDTH-2:0], div_ge};
        rem_nxt = div_ge ? div_sub : div_r[WIDTH-1:0];
        case (op_q)
            OP_MUL:          final_res = mul_acc;
            OP_DIV, OP_DIVU: final_res = neg_q ? (~quo_nxt + 1'b1) : quo_nxt;
            OP_REM, OP_REMU: final_res = neg_r ? (~rem_nxt + 1'b1) : rem_nxt;
            default:         final_res = '0;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        op_d     = op_q;
        acc_d    = acc;
        x_d      = x;
        y_d      = y;
        neg_q_d  = neg_q;
        neg_r_d  = neg_r;
        result_d = result;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    op_d    = op;
                    cnt_d   = '0;
                    acc_d   = '0;
                    neg_q_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_r_d = is_signed && a[WIDTH-1];
                    if (is_div) begin
                        x_d = abs_b;
                        y_d = abs_a;
                    end else begin
                        x_d = a;
                        y_d = b;
                    end
                    if (op > OP_REMU) begin
                        state_d  = S_DONE;
                        result_d = '0;
                    end else if (is_div && (b == '0)) begin
                        state_d  = S_DONE;
                        result_d = is_rem ? a : '1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt + 1'b1;
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc;
                    x_d   = {x[WIDTH-2:0], 1'b0};
                    y_d   = {1'b0, y[WIDTH-1:1]};
                end else begin
                    acc_d = rem_nxt;
                    y_d   = quo_nxt;
                end
                if (cnt == CNT_LAST) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    result_d = final_res;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush abandons everything except the already-returned result
        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result;
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            acc    <= '0;
            x      <= '0;
            y      <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            op_q   <= op_d;
            acc    <= acc_d;
            x      <= x_d;
            y      <= y_d;
            neg_q  <= neg_q_d;
            neg_r  <= neg_r_d;
            busy   <= busy_d;
            done   <= done_d;
            result <= result_d;
        end
    end

endmodule
